// File: rtl/dec_issue.sv
// dec_issue: decode/issue stage in front of the integer ALU.
// The stage splits the fetched word into fields and reads the 64-entry register file.
// It then registers the operands for the ALU, forwarding results that are one or two
// instructions old.
//
// Handshake: if_valid qualifies if_pc/if_inst for exactly one cycle. There is no
// ready signal because the stage never stalls. Every valid instruction is taken at
// the next rising edge unless b_is_hazard squashes it at that same edge.
module dec_issue (
  input  logic        clk,
  input  logic        rstn,
  input  logic        if_valid,
  input  logic [13:0] if_pc,
  input  logic [31:0] if_inst,
  input  logic [5:0]  wb_addr,
  input  logic [31:0] wb_val,
  input  logic        b_is_hazard,
  output logic [5:0]  ope,
  output logic [13:0] pc,
  output logic [31:0] ds_val,
  output logic [31:0] dt_val,
  output logic [5:0]  dd,
  output logic [15:0] imm,
  output logic [4:0]  opr
);

  // Opcodes that write a destination register.
  localparam logic [5:0] OP_LUI  = 6'b110000;
  localparam logic [5:0] OP_ADD  = 6'b001100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUB  = 6'b010100;
  localparam logic [5:0] OP_SLL  = 6'b011100;
  localparam logic [5:0] OP_SLLI = 6'b011000;
  localparam logic [5:0] OP_SRL  = 6'b100100;
  localparam logic [5:0] OP_SRLI = 6'b100000;
  localparam logic [5:0] OP_SRA  = 6'b101100;
  localparam logic [5:0] OP_SRAI = 6'b101000;
  localparam logic [5:0] OP_JAL  = 6'b000110;
  localparam logic [5:0] OP_JALR = 6'b001110;

  // The link register that JAL/JALR write implicitly.
  localparam logic [5:0] LINK_REG = 6'd31;

  // Register file: entry 0 exists but is never written and never read.
  logic [31:0] rf [0:63];

  // Decode fields. imm and opr deliberately overlap other fields.
  logic [5:0]  dec_ope;
  logic [5:0]  dec_dd;
  logic [5:0]  dec_ds;
  logic [5:0]  dec_dt;
  logic [15:0] dec_imm;
  logic [4:0]  dec_opr;
  logic [5:0]  dec_dst;

  // Operands after the register file read and the age-2 (wb) bypass.
  logic [31:0] rd_s;
  logic [31:0] rd_t;

  // Issue register state.
  logic [31:0] ds_q;
  logic [31:0] dt_q;
  logic        fwd_s;
  logic        fwd_t;
  logic [5:0]  dst_q;

  // The instruction is accepted at this edge; a flush overrides if_valid.
  logic load;

  assign dec_ope = if_inst[31:26];
  assign dec_dd  = if_inst[25:20];
  assign dec_ds  = if_inst[19:14];
  assign dec_dt  = if_inst[13:8];
  assign dec_imm = if_inst[15:0];
  assign dec_opr = if_inst[24:20];

  assign load = if_valid && !b_is_hazard;

  // Destination register that the ALU will write for the decoded opcode.
  always_comb begin
    dec_dst = 6'd0;
    case (dec_ope)
      OP_LUI, OP_ADD, OP_ADDI, OP_SUB, OP_SLL, OP_SLLI,
      OP_SRL, OP_SRLI, OP_SRA, OP_SRAI: dec_dst = dec_dd;
      OP_JAL, OP_JALR:                  dec_dst = LINK_REG;
      default:                          dec_dst = 6'd0;
    endcase
  end

  // Source-s read. r0 is hard zero. A result being written this cycle takes
  // precedence over the stale register file entry.
  always_comb begin
    rd_s = 32'd0;
    if (dec_ds == 6'd0) begin
      rd_s = 32'd0;
    end else if (dec_ds == wb_addr) begin
      rd_s = wb_val;
    end else begin
      rd_s = rf[dec_ds];
    end
  end

  // Source-t read, with the same rules as source s.
  always_comb begin
    rd_t = 32'd0;
    if (dec_dt == 6'd0) begin
      rd_t = 32'd0;
    end else if (dec_dt == wb_addr) begin
      rd_t = wb_val;
    end else begin
      rd_t = rf[dec_dt];
    end
  end

  // Register file write port, driven by the ALU result. Address 0 discards the write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 64; i++) begin
        rf[i] <= 32'd0;
      end
    end else if (wb_addr != 6'd0) begin
      rf[wb_addr] <= wb_val;
    end
  end

  // Issue register. It loads the decoded instruction, or a bubble when the
  // cycle is idle or the instruction is squashed. The fwd flags compare
  // against the destination of the instruction that is about to leave the
  // register. That instruction's result shows up on wb_val in the next cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ope   <= 6'd0;
      pc    <= 14'd0;
      dd    <= 6'd0;
      imm   <= 16'd0;
      opr   <= 5'd0;
      ds_q  <= 32'd0;
      dt_q  <= 32'd0;
      fwd_s <= 1'b0;
      fwd_t <= 1'b0;
      dst_q <= 6'd0;
    end else if (load) begin
      ope   <= dec_ope;
      pc    <= if_pc;
      dd    <= dec_dd;
      imm   <= dec_imm;
      opr   <= dec_opr;
      ds_q  <= rd_s;
      dt_q  <= rd_t;
      fwd_s <= (dec_ds != 6'd0) && (dec_ds == dst_q);
      fwd_t <= (dec_dt != 6'd0) && (dec_dt == dst_q);
      dst_q <= dec_dst;
    end else begin
      ope   <= 6'd0;
      pc    <= 14'd0;
      dd    <= 6'd0;
      imm   <= 16'd0;
      opr   <= 5'd0;
      ds_q  <= 32'd0;
      dt_q  <= 32'd0;
      fwd_s <= 1'b0;
      fwd_t <= 1'b0;
      dst_q <= 6'd0;
    end
  end

  // Age-1 forward: the previous instruction's result replaces the operand
  // that was captured at decode.
  assign ds_val = fwd_s ? wb_val : ds_q;
  assign dt_val = fwd_t ? wb_val : dt_q;

endmodule

// File: tb/tb_dec_issue.sv
// Directed bench for dec_issue. The bench drives wb_addr/wb_val the way the
// ALU would drive them. In each cycle, they carry the result of the instruction
// that sat in the issue register during the previous cycle. Every value is
// computed by hand.
module tb_dec_issue;

  logic        clk;
  logic        rstn;
  logic        if_valid;
  logic [13:0] if_pc;
  logic [31:0] if_inst;
  logic [5:0]  wb_addr;
  logic [31:0] wb_val;
  logic        b_is_hazard;
  logic [5:0]  ope;
  logic [13:0] pc;
  logic [31:0] ds_val;
  logic [31:0] dt_val;
  logic [5:0]  dd;
  logic [15:0] imm;
  logic [4:0]  opr;

  int n_vec;
  int n_err;

  localparam logic [5:0] OP_ADD  = 6'b001100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUB  = 6'b010100;
  localparam logic [5:0] OP_JAL  = 6'b000110;
  localparam logic [5:0] OP_BR   = 6'b010010;

  dec_issue dut (
    .clk         (clk),
    .rstn        (rstn),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .wb_addr     (wb_addr),
    .wb_val      (wb_val),
    .b_is_hazard (b_is_hazard),
    .ope         (ope),
    .pc          (pc),
    .ds_val      (ds_val),
    .dt_val      (dt_val),
    .dd          (dd),
    .imm         (imm),
    .opr         (opr)
  );

  // Clock: 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds an R-type word.
  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [5:0] d,
                                        input logic [5:0] s, input logic [5:0] t);
    return {op, d, s, t, 8'h00};
  endfunction

  // Builds an I-type word with ds = r0. Only small immediates are used.
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [5:0] d,
                                        input logic [15:0] k);
    return {op, d, 4'b0000, k};
  endfunction

  // Presents one cycle of stimulus at the falling edge. It then waits 1 time
  // unit so that the outputs, which combine with wb_val, settle before checks.
  task automatic cyc(input logic v, input logic [13:0] p, input logic [31:0] inst,
                     input logic [5:0] wa, input logic [31:0] wv, input logic hz);
    @(negedge clk);
    if_valid    = v;
    if_pc       = p;
    if_inst     = inst;
    wb_addr     = wa;
    wb_val      = wv;
    b_is_hazard = hz;
    #1;
  endtask

  // Compares one value and counts any miscompare.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rstn        = 1'b0;
    if_valid    = 1'b0;
    if_pc       = 14'd0;
    if_inst     = 32'd0;
    wb_addr     = 6'd0;
    wb_val      = 32'd0;
    b_is_hazard = 1'b0;

    // Reset held while random inputs are applied.
    repeat (4) cyc(1'($urandom_range(0, 1)), 14'($urandom), $urandom,
                   6'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 1)));
    chk("rst_ope", 32'(ope), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_dd", 32'(dd), 32'd0);
    chk("rst_imm", 32'(imm), 32'd0);
    chk("rst_opr", 32'(opr), 32'd0);
    chk("rst_ds_val", ds_val, 32'd0);
    chk("rst_dt_val", dt_val, 32'd0);
    cyc(1'b0, 14'd0, 32'd0, 6'd0, 32'd0, 1'b0);
    rstn = 1'b1;

    // The first decode after release sees an all-zero register file.
    cyc(1'b1, 14'd0, rtype(OP_ADD, 6'd1, 6'd2, 6'd3), 6'd0, 32'd0, 1'b0);
    cyc(1'b0, 14'd0, 32'd0, 6'd0, 32'd0, 1'b0);
    chk("post_rst_ope", 32'(ope), 32'(OP_ADD));
    chk("post_rst_ds", ds_val, 32'd0);
    chk("post_rst_dt", dt_val, 32'd0);

    // Independent issue: preload r2=5 and r3=7, then ADD r1,r2,r3.
    cyc(1'b0, 14'd0, 32'd0, 6'd2, 32'd5, 1'b0);
    cyc(1'b0, 14'd0, 32'd0, 6'd3, 32'd7, 1'b0);
    cyc(1'b1, 14'h10, rtype(OP_ADD, 6'd1, 6'd2, 6'd3), 6'd0, 32'd0, 1'b0);
    cyc(1'b0, 14'd0, 32'd0, 6'd1, 32'd12, 1'b0);
    chk("ind_ope", 32'(ope), 32'(OP_ADD));
    chk("ind_ds", ds_val, 32'd5);
    chk("ind_dt", dt_val, 32'd7);
    chk("ind_dd", 32'(dd), 32'd1);
    chk("ind_pc", 32'(pc), 32'h10);

    // Back-to-back forward: ADDI r4,r0,9 followed by SUB r5,r4,r4.
    cyc(1'b1, 14'h11, itype(OP_ADDI, 6'd4, 16'd9), 6'd0, 32'd0, 1'b0);
    cyc(1'b1, 14'h12, rtype(OP_SUB, 6'd5, 6'd4, 6'd4), 6'd0, 32'd0, 1'b0);
    chk("b2b_addi_ope", 32'(ope), 32'(OP_ADDI));
    chk("b2b_addi_imm", 32'(imm), 32'd9);
    chk("b2b_addi_opr", 32'(opr), 32'd4);
    chk("b2b_addi_pc", 32'(pc), 32'h11);
    cyc(1'b0, 14'd0, 32'd0, 6'd4, 32'd9, 1'b0);
    chk("b2b_sub_ope", 32'(ope), 32'(OP_SUB));
    chk("b2b_sub_ds", ds_val, 32'd9);
    chk("b2b_sub_dt", dt_val, 32'd9);
    cyc(1'b0, 14'd0, 32'd0, 6'd5, 32'd0, 1'b0);
    cyc(1'b1, 14'h13, rtype(OP_ADD, 6'd10, 6'd4, 6'd5), 6'd0, 32'd0, 1'b0);
    cyc(1'b0, 14'd0, 32'd0, 6'd10, 32'd9, 1'b0);
    chk("b2b_r4_rf", ds_val, 32'd9);
    chk("b2b_r5_rf", dt_val, 32'd0);

    // Age-2 bypass: ADDI r6,r0,3; ADD r12,r2,r3; ADD r7,r6,r6.
    cyc(1'b1, 14'h14, itype(OP_ADDI, 6'd6, 16'd3), 6'd0, 32'd0, 1'b0);
    cyc(1'b1, 14'h15, rtype(OP_ADD, 6'd12, 6'd2, 6'd3), 6'd0, 32'd0, 1'b0);
    cyc(1'b1, 14'h16, rtype(OP_ADD, 6'd7, 6'd6, 6'd6), 6'd6, 32'd3, 1'b0);
    cyc(1'b0, 14'd0, 32'd0, 6'd12, 32'd12, 1'b0);
    chk("age2_ds", ds_val, 32'd3);
    chk("age2_dt", dt_val, 32'd3);
    cyc(1'b0, 14'd0, 32'd0, 6'd7, 32'd6, 1'b0);
    cyc(1'b1, 14'h17, rtype(OP_ADD, 6'd13, 6'd7, 6'd0), 6'd0, 32'd0, 1'b0);
    cyc(1'b0, 14'd0, 32'd0, 6'd13, 32'd6, 1'b0);
    chk("age2_r7_rf", ds_val, 32'd6);

    // Register 0: ADDI r0,r0,1, then ADD r8,r0,r0 must not forward.
    cyc(1'b1, 14'h18, itype(OP_ADDI, 6'd0, 16'd1), 6'd0, 32'd0, 1'b0);
    cyc(1'b1, 14'h19, rtype(OP_ADD, 6'd8, 6'd0, 6'd0), 6'd0, 32'd0, 1'b0);
    cyc(1'b0, 14'd0, 32'd0, 6'd0, 32'd1, 1'b0);
    chk("r0_ds", ds_val, 32'd0);
    chk("r0_dt", dt_val, 32'd0);

    // Branch flush: the ALU resolves the branch taken while ADDI r9 arrives.
    cyc(1'b1, 14'h1a, {OP_BR, 6'd3, 4'b0000, 16'h0007}, 6'd0, 32'd0, 1'b0);
    cyc(1'b1, 14'h1b, itype(OP_ADDI, 6'd9, 16'd1), 6'd0, 32'd0, 1'b1);
    chk("br_ope", 32'(ope), 32'(OP_BR));
    chk("br_imm", 32'(imm), 32'h7);
    chk("br_opr", 32'(opr), 32'd3);
    cyc(1'b1, 14'h1c, rtype(OP_ADD, 6'd14, 6'd9, 6'd9), 6'd0, 32'hdeadbeef, 1'b0);
    chk("flush_ope", 32'(ope), 32'd0);
    chk("flush_pc", 32'(pc), 32'd0);
    chk("flush_dd", 32'(dd), 32'd0);
    chk("flush_imm", 32'(imm), 32'd0);
    chk("flush_ds", ds_val, 32'd0);
    cyc(1'b0, 14'd0, 32'd0, 6'd0, 32'hdeadbeef, 1'b0);
    chk("after_flush_ope", 32'(ope), 32'(OP_ADD));
    chk("after_flush_pc", 32'(pc), 32'h1c);
    chk("after_flush_dd", 32'(dd), 32'd14);
    chk("after_flush_ds", ds_val, 32'd0);
    chk("after_flush_dt", dt_val, 32'd0);

    // JAL at pc 0x20, then a dependent read of r31.
    cyc(1'b1, 14'h20, {OP_JAL, 26'd5}, 6'd0, 32'd0, 1'b0);
    cyc(1'b1, 14'h21, rtype(OP_ADD, 6'd15, 6'd31, 6'd0), 6'd0, 32'd0, 1'b0);
    chk("jal_ope", 32'(ope), 32'(OP_JAL));
    chk("jal_pc", 32'(pc), 32'h20);
    cyc(1'b0, 14'd0, 32'd0, 6'd31, 32'h21, 1'b0);
    chk("jal_fwd_ds", ds_val, 32'h21);
    chk("jal_fwd_dt", dt_val, 32'd0);

    // Reset mid-stream, with ADD r16,r2,r3 in the issue register.
    cyc(1'b1, 14'h22, rtype(OP_ADD, 6'd16, 6'd2, 6'd3), 6'd15, 32'h21, 1'b0);
    cyc(1'b0, 14'd0, 32'd0, 6'd0, 32'd0, 1'b0);
    chk("mid_pre_ds", ds_val, 32'd5);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_ope", 32'(ope), 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'd0);
    chk("mid_rst_ds", ds_val, 32'd0);
    cyc(1'b0, 14'd0, 32'd0, 6'd0, 32'd0, 1'b0);
    rstn = 1'b1;
    cyc(1'b1, 14'h23, rtype(OP_ADD, 6'd16, 6'd2, 6'd3), 6'd0, 32'd0, 1'b0);
    cyc(1'b0, 14'd0, 32'd0, 6'd0, 32'd0, 1'b0);
    chk("mid_post_ope", 32'(ope), 32'(OP_ADD));
    chk("mid_post_ds", ds_val, 32'd0);
    chk("mid_post_dt", dt_val, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dec_issue.md
# dec_issue

Decode/issue stage sitting directly upstream of the integer ALU. It accepts one fetched instruction per cycle, splits it into operation and operand fields, reads a 64-entry register file that the ALU result port writes, and presents registered operands to the ALU. It forwards back-to-back results without stalling and squashes the wrong-path instruction when the ALU resolves a taken branch.

## Interface
- No parameters; all widths fixed.
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch presents a valid instruction this cycle
- if_pc  in  14  PC of the fetched instruction
- if_inst  in  32  instruction word
- wb_addr  in  6  ALU result destination; 0 means no write
- wb_val  in  32  ALU result value
- b_is_hazard  in  1  ALU taken-branch/jump indication, combinational from the ALU inputs
- ope  out  6  operation code to ALU
- pc  out  14  PC of the issued instruction
- ds_val  out  32  source-s operand, forwarded
- dt_val  out  32  source-t operand, forwarded
- dd  out  6  destination field
- imm  out  16  immediate
- opr  out  5  compare-immediate field for branches

## Operation
- Field split: ope=inst[31:26], dd=inst[25:20], ds=inst[19:14], dt=inst[13:8], imm=inst[15:0], opr=inst[24:20]. imm/opr overlap other fields by design.
- Register file: 64 x 32 flops. All entries clear to 0 on reset. Write on the clock edge when wb_addr != 0. Reads of address 0 always return 0.
- Read bypass at decode: src==0 -> 0; src==wb_addr (nonzero) -> wb_val; otherwise the register file entry.
- Issue register: on each edge, if_valid=1 with no flush loads all fields plus bypassed ds_q/dt_q. if_valid=0 loads a bubble: ope=0, dd=0, imm=0, opr=0, pc=0, ds_q=dt_q=0.
- Destination of the issued instruction (dst_q, registered alongside):
  - dd for LUI 110000, ADD 001100, ADDI 001000, SUB 010100, SLL 011100, SLLI 011000, SRL 100100, SRLI 100000, SRA 101100, SRAI 101000.
  - 31 for JAL 000110 and JALR 001110.
  - 0 otherwise.
- Back-to-back forward: when loading, set fwd_s=1 if ds!=0 and ds==dst of the instruction currently in the issue register; same rule for fwd_t/dt. Outputs ds_val = fwd_s ? wb_val : ds_q and dt_val = fwd_t ? wb_val : dt_q. This output mux is the only combinational path to the outputs.
- Forward priority: back-to-back forward (age 1) overrides read bypass (age 2), which overrides the register file.
- Flush: b_is_hazard=1 at an edge loads a bubble regardless of if_valid. The arriving instruction is dropped, and fwd_s, fwd_t and dst_q are cleared. Fetch redirects in the same cycle, so exactly one instruction is squashed.
- There are no stall conditions. The stage accepts every cycle.

## Timing
- Latency: instruction presented at edge N is on the outputs after edge N, and the ALU consumes it in cycle N+1.
- Reset (async assert, synchronous deassert by the upstream reset tree): ope, pc, dd, imm, opr, ds_q, dt_q, fwd_s, fwd_t, dst_q = 0. Therefore ds_val=dt_val=0 and all registers read 0.
- Reset mid-stream: any in-flight instruction is lost, and the first instruction after release sees an all-zero register file.
- Simultaneous wb write and decode read of the same address: the new wb_val is used, never the stale entry.
- Dependent instruction directly after a JAL: ds==31 gets pc_jal+1 via fwd_s.
- Flush and if_valid in the same cycle: flush wins.
- The bubble in the issue register after a flush produces dst_q=0, so no false forward.

## Test plan
- Reset: hold rstn=0 with random inputs. All outputs are 0. After release, a decode of ADD r1,r2,r3 gives ds_val=dt_val=0.
- Independent issue: preload r2=5 and r3=7 via wb. Issue ADD dd=1, ds=2, dt=3 with if_pc=0x10. Next cycle: ope=001100, ds_val=5, dt_val=7, dd=1, pc=0x10.
- Back-to-back forward: ADDI r4,r0,9 followed immediately by SUB r5,r4,r4 with the ALU model in the loop. SUB sees ds_val=dt_val=9, and r5=0.
- Age-2 bypass: ADDI r6,r0,3, then an unrelated instruction, then ADD r7,r6,r6. The third instruction reads 3 through the wb bypass in its decode cycle, and r7=6.
- Register 0: ADDI with dd=0 and imm=1, followed by ADD r8,r0,r0. ds_val=dt_val=0 with no forward.
- Branch flush: a branch with b_is_hazard=1 is followed by if_valid=1 with ADDI r9,r0,1. The next cycle's ope=0, r9 is unchanged, and the following instruction issues normally.
